// File: rtl/rtmq_timer_mc.sv
// Multi-channel countdown timer with one-shot/periodic modes, sticky expiry flags,
// overrun and invalid-duration detection, plus a loadable free-running wall clock.
module rtmq_timer_mc #(
  parameter int N_CH  = 4,
  parameter int W_CH  = 2,
  parameter int W_DUR = 32,
  parameter int W_WCK = 64,
  parameter int N_MND = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [W_CH-1:0]  wr_ch,
  input  logic [1:0]       wr_mode,
  input  logic [W_DUR-1:0] wr_dur,
  input  logic [N_CH-1:0]  ack,
  input  logic             wck_ld,
  input  logic [W_WCK-1:0] wck_val,
  output logic [N_CH-1:0]  tim_flg,
  output logic [N_CH-1:0]  tim_pls,
  output logic [N_CH-1:0]  tim_bsy,
  output logic [N_CH-1:0]  tim_ovr,
  output logic [N_CH-1:0]  tim_err,
  output logic [W_WCK-1:0] wck
);

  logic [W_DUR-1:0] cnt [N_CH];
  logic [W_DUR-1:0] dur [N_CH];
  logic [N_CH-1:0]  per;
  logic [N_CH-1:0]  sel;
  logic [N_CH-1:0]  expire;

  function automatic logic dur_ok(input logic [W_DUR-1:0] d);
    return d > W_DUR'(N_MND);
  endfunction

  // An out-of-range wr_ch matches no channel, so the command falls away here.
  always_comb begin
    sel    = '0;
    expire = '0;
    for (int i = 0; i < N_CH; i++) begin
      sel[i]    = wr_en && (int'(wr_ch) == i);
      expire[i] = tim_bsy[i] && (cnt[i] == W_DUR'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= '0;
        dur[i] <= '0;
      end
      per     <= '0;
      tim_flg <= '0;
      tim_pls <= '0;
      tim_bsy <= '0;
      tim_ovr <= '0;
      tim_err <= '0;
      wck     <= '0;
    end else begin
      wck <= wck_ld ? wck_val : wck + 1'b1;
      for (int i = 0; i < N_CH; i++) begin
        tim_pls[i] <= 1'b0;
        // Ack clears first so that any set below on the same edge wins.
        if (ack[i]) begin
          tim_flg[i] <= 1'b0;
          tim_ovr[i] <= 1'b0;
          tim_err[i] <= 1'b0;
        end
        if (sel[i]) begin
          if (wr_mode == 2'b01 || wr_mode == 2'b10) begin
            if (dur_ok(wr_dur)) begin
              cnt[i]     <= wr_dur;
              dur[i]     <= wr_dur;
              per[i]     <= wr_mode[1];
              tim_bsy[i] <= 1'b1;
            end else begin
              tim_bsy[i] <= 1'b0;
              tim_pls[i] <= 1'b1;
              tim_flg[i] <= 1'b1;
              tim_err[i] <= 1'b1;
            end
          end else begin
            tim_bsy[i] <= 1'b0;
          end
        end else if (expire[i]) begin
          tim_pls[i] <= 1'b1;
          tim_flg[i] <= 1'b1;
          if (tim_flg[i] && !ack[i])
            tim_ovr[i] <= 1'b1;
          if (per[i]) begin
            cnt[i] <= dur[i];
          end else begin
            cnt[i]     <= cnt[i] - 1'b1;
            tim_bsy[i] <= 1'b0;
          end
        end else if (tim_bsy[i]) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rtmq_timer_mc.sv
// Directed bench for rtmq_timer_mc; expiry pulses are tracked by a scoreboard of
// (channel, edge) entries, other outputs are checked at fixed points in the sequence.
module tb_rtmq_timer_mc;
  localparam int N_CH  = 4;
  localparam int W_CH  = 2;
  localparam int W_DUR = 32;
  localparam int W_WCK = 64;
  localparam int N_MND = 9;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic [W_CH-1:0]  wr_ch = '0;
  logic [1:0]       wr_mode = '0;
  logic [W_DUR-1:0] wr_dur = '0;
  logic [N_CH-1:0]  ack = '0;
  logic             wck_ld = 1'b0;
  logic [W_WCK-1:0] wck_val = '0;
  logic [N_CH-1:0]  tim_flg, tim_pls, tim_bsy, tim_ovr, tim_err;
  logic [W_WCK-1:0] wck;

  rtmq_timer_mc #(.N_CH(N_CH), .W_CH(W_CH), .W_DUR(W_DUR), .W_WCK(W_WCK), .N_MND(N_MND)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_mode(wr_mode), .wr_dur(wr_dur),
    .ack(ack), .wck_ld(wck_ld), .wck_val(wck_val), .tim_flg(tim_flg), .tim_pls(tim_pls),
    .tim_bsy(tim_bsy), .tim_ovr(tim_ovr), .tim_err(tim_err), .wck(wck)
  );

  always #5 clk = ~clk;

  int unsigned edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int          ch;
    int unsigned e;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input int ch, input int unsigned e);
    exp_t x;
    x.ch = ch;
    x.e  = e;
    sb.push_back(x);
  endtask

  // One clock edge, then compare pulses against scoreboard entries due at this edge.
  task automatic step();
    logic [N_CH-1:0] emask;
    @(posedge clk);
    @(negedge clk);
    emask = '0;
    for (int j = sb.size() - 1; j >= 0; j--) begin
      if (sb[j].e == edge_n) begin
        emask[sb[j].ch] = 1'b1;
        sb.delete(j);
      end
    end
    if (tim_pls != '0 || emask != '0)
      chk($sformatf("pls_e%0d", edge_n), tim_pls, emask);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic cmd(input int ch, input logic [1:0] mode, input logic [W_DUR-1:0] d,
                     input bit do_push, output int unsigned e0);
    e0 = edge_n + 1;
    if (do_push && (mode == 2'b01 || mode == 2'b10))
      push(ch, (d > W_DUR'(N_MND)) ? e0 + d : e0);
    wr_en   = 1'b1;
    wr_ch   = ch[W_CH-1:0];
    wr_mode = mode;
    wr_dur  = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic do_ack(input logic [N_CH-1:0] m);
    ack = m;
    step();
    ack = '0;
  endtask

  initial begin
    int unsigned e0, e;
    logic [W_WCK-1:0] w;

    // reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_flg", tim_flg, 0);
    chk("rst_pls", tim_pls, 0);
    chk("rst_bsy", tim_bsy, 0);
    chk("rst_ovr", tim_ovr, 0);
    chk("rst_err", tim_err, 0);
    chk("rst_wck", wck, 0);
    rst = 1'b0;
    step();
    chk("wck_after_rel", wck, 1);

    // ch0 one-shot D=20
    cmd(0, 2'b01, 20, 1, e0);
    for (int k = 0; k <= 20; k++) begin
      chk($sformatf("bsy0_k%0d", k), tim_bsy[0], (k < 20));
      if (k < 20) step();
    end
    chk("flg0_oneshot", tim_flg[0], 1);
    chk("ovr0_oneshot", tim_ovr[0], 0);

    // ch1 periodic D=12, overrun, ack, stop
    cmd(1, 2'b10, 12, 1, e0);
    push(1, e0 + 24);
    run(12);
    chk("flg1_p1", tim_flg[1], 1);
    chk("ovr1_p1", tim_ovr[1], 0);
    run(12);
    chk("ovr1_p2", tim_ovr[1], 1);
    chk("flg1_p2", tim_flg[1], 1);
    chk("bsy1_p2", tim_bsy[1], 1);
    do_ack(4'b0010);
    chk("flg1_ack", tim_flg[1], 0);
    chk("ovr1_ack", tim_ovr[1], 0);
    cmd(1, 2'b00, 0, 0, e0);
    chk("bsy1_stop", tim_bsy[1], 0);
    run(15);

    // stop via mode 11 leaves flags alone
    cmd(0, 2'b01, 20, 0, e0);
    run(5);
    cmd(0, 2'b11, 0, 0, e0);
    chk("bsy0_stop11", tim_bsy[0], 0);
    chk("flg0_stop11", tim_flg[0], 1);
    run(25);

    // ack and expiry on the same edge
    cmd(0, 2'b01, 10, 1, e0);
    run(9);
    do_ack(4'b0001);
    chk("flg0_ack_vs_set", tim_flg[0], 1);
    chk("ovr0_ack_vs_set", tim_ovr[0], 0);

    // ch2 invalid durations, then minimum legal duration
    cmd(2, 2'b01, 5, 1, e0);
    chk("flg2_d5", tim_flg[2], 1);
    chk("err2_d5", tim_err[2], 1);
    chk("bsy2_d5", tim_bsy[2], 0);
    do_ack(4'b0100);
    chk("err2_ack", tim_err[2], 0);
    chk("flg2_ack", tim_flg[2], 0);
    cmd(2, 2'b10, 9, 1, e0);
    chk("err2_d9", tim_err[2], 1);
    chk("bsy2_d9", tim_bsy[2], 0);
    do_ack(4'b0100);
    cmd(2, 2'b01, 0, 1, e0);
    chk("err2_d0", tim_err[2], 1);
    do_ack(4'b0100);
    cmd(2, 2'b01, 10, 1, e0);
    chk("bsy2_d10", tim_bsy[2], 1);
    chk("err2_d10", tim_err[2], 0);
    run(10);
    chk("bsy2_d10_done", tim_bsy[2], 0);
    chk("flg2_d10_done", tim_flg[2], 1);

    // ch3 rewrite on its expiry edge discards that expiry
    cmd(3, 2'b01, 30, 0, e0);
    run(29);
    cmd(3, 2'b01, 15, 1, e);
    chk("flg3_rewrite", tim_flg[3], 0);
    chk("bsy3_rewrite", tim_bsy[3], 1);
    run(15);
    chk("flg3_after", tim_flg[3], 1);

    // all four channels expiring together
    do_ack(4'b1111);
    e = edge_n + 1;
    cmd(0, 2'b01, 40, 1, e0);
    cmd(1, 2'b01, 39, 1, e0);
    cmd(2, 2'b01, 38, 1, e0);
    cmd(3, 2'b01, 37, 1, e0);
    run(int'(e + 39 - edge_n));
    chk("pls_all_before", tim_pls, 0);
    step();
    chk("pls_all", tim_pls, 4'b1111);
    chk("bsy_all_done", tim_bsy, 0);

    // wall clock increment, load and wrap
    w = wck;
    step();
    chk("wck_inc", wck, w + 1);
    wck_ld  = 1'b1;
    wck_val = 64'hFFFF_FFFF_FFFF_FFFE;
    step();
    wck_ld  = 1'b0;
    chk("wck_ld", wck, 64'hFFFF_FFFF_FFFF_FFFE);
    step();
    chk("wck_max", wck, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    chk("wck_wrap", wck, 0);

    // reset in the middle of counting
    cmd(0, 2'b01, 50, 0, e0);
    cmd(1, 2'b10, 12, 1, e0);
    run(13);
    chk("flg1_pre_rst", tim_flg[1], 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_flg", tim_flg, 0);
    chk("mid_rst_bsy", tim_bsy, 0);
    chk("mid_rst_pls", tim_pls, 0);
    chk("mid_rst_ovr", tim_ovr, 0);
    chk("mid_rst_err", tim_err, 0);
    chk("mid_rst_wck", wck, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run(60);
    chk("bsy_post_rst", tim_bsy, 0);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
